// File: rtl/video_timing_sink.sv
// Display-side raster timing generator and pixel sink.
// Requests one pixel per active position via VideoReady, samples video on that
// same edge and presents registered RGB with syncs, DataEnable and coordinates.
module video_timing_sink #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter bit          SYNC_POL = 1'b1,
    parameter int unsigned CW       = 12
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Enable,
    input  logic [23:0]   video,
    output logic          VideoReady,
    output logic [7:0]    Red,
    output logic [7:0]    Green,
    output logic [7:0]    Blue,
    output logic          DataEnable,
    output logic          HSync,
    output logic          VSync,
    output logic          FrameStart,
    output logic [CW-1:0] PixelX,
    output logic [CW-1:0] PixelY
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;

    logic          running;
    logic          h_last;
    logic          frame_last;
    logic          h_in_sync;
    logic          v_in_sync;

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: frames stop only after their last cycle
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (Enable) next_state = S_RUN;
            end
            S_RUN: begin
                if (!Enable) next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (Enable)          next_state = S_RUN;
                else if (frame_last) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output/decode logic: raster region flags and the pixel request strobe
    always_comb begin
        running    = (state != S_IDLE);
        h_last     = (h_cnt == H_LAST);
        frame_last = h_last && (v_cnt == V_LAST);
        h_in_sync  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        v_in_sync  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        VideoReady = running && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    end

    // Raster counters: held at zero while idle, free-running otherwise
    always_ff @(posedge Clock) begin
        if (Reset || !running) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
        end else begin
            h_cnt <= h_cnt + CW'(1);
        end
    end

    // Registered output stage, one cycle behind the counters
    always_ff @(posedge Clock) begin
        if (Reset) begin
            {Red, Green, Blue} <= 24'h0;
            DataEnable         <= 1'b0;
            HSync              <= SYNC_OFF;
            VSync              <= SYNC_OFF;
            FrameStart         <= 1'b0;
            PixelX             <= '0;
            PixelY             <= '0;
        end else begin
            {Red, Green, Blue} <= VideoReady ? video : 24'h0;
            DataEnable         <= VideoReady;
            HSync              <= (running && h_in_sync) ? SYNC_ON : SYNC_OFF;
            VSync              <= (running && v_in_sync) ? SYNC_ON : SYNC_OFF;
            FrameStart         <= running && (h_cnt == '0) && (v_cnt == '0);
            PixelX             <= h_cnt;
            PixelY             <= v_cnt;
        end
    end

endmodule

// File: tb/tb_video_timing_sink.sv
// Directed bench for video_timing_sink with an 8x6 raster (4x3 active pixels).
module tb_video_timing_sink;

    logic        Clock;
    logic        Reset;
    logic        Enable;
    logic [23:0] video;
    logic        VideoReady;
    logic [7:0]  Red;
    logic [7:0]  Green;
    logic [7:0]  Blue;
    logic        DataEnable;
    logic        HSync;
    logic        VSync;
    logic        FrameStart;
    logic [3:0]  PixelX;
    logic [3:0]  PixelY;

    int checks;
    int errors;

    video_timing_sink #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .CW(4)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Enable    (Enable),
        .video     (video),
        .VideoReady(VideoReady),
        .Red       (Red),
        .Green     (Green),
        .Blue      (Blue),
        .DataEnable(DataEnable),
        .HSync     (HSync),
        .VSync     (VSync),
        .FrameStart(FrameStart),
        .PixelX    (PixelX),
        .PixelY    (PixelY)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Expected raster decode for a phase 0..47 within the 48-cycle frame
    function automatic logic exp_vr(int p);
        return ((p % 8) < 4) && ((p / 8) < 3);
    endfunction

    function automatic logic exp_hs(int p);
        return ((p % 8) == 5) || ((p % 8) == 6);
    endfunction

    function automatic logic exp_vs(int p);
        return (p / 8) == 4;
    endfunction

    function automatic logic [23:0] pat(int n);
        return {8'(n + 1), 8'(n + 65), 8'(n + 129)};
    endfunction

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset;
        Reset  = 1'b1;
        Enable = 1'b0;
        video  = 24'hFFFFFF;
        tick();
        tick();
        checks++;
        if (VideoReady !== 1'b0) begin errors++; $display("FAIL reset_vr got %b want 0", VideoReady); end
        checks++;
        if ({Red, Green, Blue} !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h want 000000", {Red, Green, Blue}); end
        checks++;
        if (DataEnable !== 1'b0 || FrameStart !== 1'b0) begin errors++; $display("FAIL reset_de_fs got %b%b want 00", DataEnable, FrameStart); end
        checks++;
        if (HSync !== 1'b0 || VSync !== 1'b0) begin errors++; $display("FAIL reset_sync got %b%b want 00", HSync, VSync); end
        checks++;
        if (PixelX !== 4'd0 || PixelY !== 4'd0) begin errors++; $display("FAIL reset_xy got %0d,%0d want 0,0", PixelX, PixelY); end
    endtask

    // Two continuous frames with a ramp on video; covers timing, data path, syncs, FrameStart
    task automatic test_frames;
        int pulses;
        int vs_hi;
        int fs_cnt;
        int p;
        int q;
        logic [23:0] exp_rgb;
        pulses = 0; vs_hi = 0; fs_cnt = 0;
        Reset  = 1'b0;
        Enable = 1'b1;
        tick();
        for (int n = 0; n <= 96; n++) begin
            p = n % 48;
            checks++;
            if (VideoReady !== exp_vr(p)) begin errors++; $display("FAIL frm_vr n=%0d got %b want %b", n, VideoReady, exp_vr(p)); end
            if (n < 96 && VideoReady) pulses++;
            if (n >= 1) begin
                q = (n - 1) % 48;
                exp_rgb = exp_vr(q) ? pat(n - 1) : 24'h0;
                if (VSync) vs_hi++;
                if (FrameStart) fs_cnt++;
                checks++;
                if (DataEnable !== exp_vr(q)) begin errors++; $display("FAIL frm_de n=%0d got %b want %b", n, DataEnable, exp_vr(q)); end
                checks++;
                if ({Red, Green, Blue} !== exp_rgb) begin errors++; $display("FAIL frm_rgb n=%0d got %h want %h", n, {Red, Green, Blue}, exp_rgb); end
                checks++;
                if (HSync !== exp_hs(q)) begin errors++; $display("FAIL frm_hs n=%0d got %b want %b", n, HSync, exp_hs(q)); end
                checks++;
                if (VSync !== exp_vs(q)) begin errors++; $display("FAIL frm_vs n=%0d got %b want %b", n, VSync, exp_vs(q)); end
                checks++;
                if (FrameStart !== (q == 0)) begin errors++; $display("FAIL frm_fs n=%0d got %b want %b", n, FrameStart, q == 0); end
                checks++;
                if (PixelX !== 4'(q % 8) || PixelY !== 4'(q / 8)) begin
                    errors++; $display("FAIL frm_xy n=%0d got %0d,%0d want %0d,%0d", n, PixelX, PixelY, q % 8, q / 8);
                end
            end
            if (n < 96) begin
                video = pat(n);
                tick();
            end
        end
        checks++;
        if (pulses !== 24) begin errors++; $display("FAIL frm_pulses got %0d want 24", pulses); end
        checks++;
        if (vs_hi !== 16) begin errors++; $display("FAIL frm_vs_cycles got %0d want 16", vs_hi); end
        checks++;
        if (fs_cnt !== 2) begin errors++; $display("FAIL frm_fs_count got %0d want 2", fs_cnt); end
    endtask

    // Enable dropped at cycle 20: frame completes, then idle, then restart
    task automatic test_drain;
        int pulses;
        pulses = 0;
        for (int p = 0; p < 48; p++) begin
            checks++;
            if (VideoReady !== exp_vr(p)) begin errors++; $display("FAIL drn_vr p=%0d got %b want %b", p, VideoReady, exp_vr(p)); end
            if (VideoReady) pulses++;
            if (p >= 1) begin
                checks++;
                if (PixelX !== 4'((p - 1) % 8) || HSync !== exp_hs(p - 1)) begin
                    errors++; $display("FAIL drn_timing p=%0d got x=%0d hs=%b want x=%0d hs=%b", p, PixelX, HSync, (p - 1) % 8, exp_hs(p - 1));
                end
            end
            if (p == 20) Enable = 1'b0;
            video = pat(p);
            tick();
        end
        checks++;
        if (pulses !== 12) begin errors++; $display("FAIL drn_pulses got %0d want 12", pulses); end
        checks++;
        if (VideoReady !== 1'b0) begin errors++; $display("FAIL drn_idle_vr got %b want 0", VideoReady); end
        checks++;
        if (PixelX !== 4'd7 || PixelY !== 4'd5) begin errors++; $display("FAIL drn_last_xy got %0d,%0d want 7,5", PixelX, PixelY); end
        tick();
        tick();
        checks++;
        if (VideoReady !== 1'b0 || DataEnable !== 1'b0) begin errors++; $display("FAIL idle_vr_de got %b%b want 00", VideoReady, DataEnable); end
        checks++;
        if (HSync !== 1'b0 || VSync !== 1'b0) begin errors++; $display("FAIL idle_sync got %b%b want 00", HSync, VSync); end
        checks++;
        if (PixelX !== 4'd0 || PixelY !== 4'd0) begin errors++; $display("FAIL idle_xy got %0d,%0d want 0,0", PixelX, PixelY); end
        Enable = 1'b1;
        tick();
        checks++;
        if (VideoReady !== 1'b1) begin errors++; $display("FAIL restart_vr got %b want 1", VideoReady); end
        checks++;
        if (DataEnable !== 1'b0) begin errors++; $display("FAIL restart_de got %b want 0", DataEnable); end
    endtask

    // Enable toggled 1->0->1 mid-frame: timing and pulse count unaffected
    task automatic test_toggle;
        int pulses;
        pulses = 0;
        for (int p = 0; p < 48; p++) begin
            checks++;
            if (VideoReady !== exp_vr(p)) begin errors++; $display("FAIL tog_vr p=%0d got %b want %b", p, VideoReady, exp_vr(p)); end
            if (VideoReady) pulses++;
            if (p >= 1) begin
                checks++;
                if (PixelX !== 4'((p - 1) % 8) || PixelY !== 4'((p - 1) / 8) || VSync !== exp_vs(p - 1)) begin
                    errors++; $display("FAIL tog_timing p=%0d got %0d,%0d vs=%b want %0d,%0d vs=%b",
                                       p, PixelX, PixelY, VSync, (p - 1) % 8, (p - 1) / 8, exp_vs(p - 1));
                end
            end
            if (p == 10) Enable = 1'b0;
            if (p == 15) Enable = 1'b1;
            video = pat(p);
            tick();
        end
        checks++;
        if (pulses !== 12) begin errors++; $display("FAIL tog_pulses got %0d want 12", pulses); end
        checks++;
        if (VideoReady !== 1'b1) begin errors++; $display("FAIL tog_next_frame_vr got %b want 1", VideoReady); end
    endtask

    // Reset in the middle of an active line
    task automatic test_reset_mid;
        tick();
        checks++;
        if (FrameStart !== 1'b1) begin errors++; $display("FAIL mid_fs got %b want 1", FrameStart); end
        tick();
        checks++;
        if (VideoReady !== 1'b1 || DataEnable !== 1'b1) begin errors++; $display("FAIL mid_active got %b%b want 11", VideoReady, DataEnable); end
        Reset  = 1'b1;
        Enable = 1'b0;
        video  = 24'h123456;
        tick();
        checks++;
        if (VideoReady !== 1'b0 || DataEnable !== 1'b0 || FrameStart !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ctl got vr=%b de=%b fs=%b want 000", VideoReady, DataEnable, FrameStart);
        end
        checks++;
        if ({Red, Green, Blue} !== 24'h0 || HSync !== 1'b0 || VSync !== 1'b0) begin
            errors++; $display("FAIL mid_rst_out got rgb=%h hs=%b vs=%b want 000000 0 0", {Red, Green, Blue}, HSync, VSync);
        end
        checks++;
        if (PixelX !== 4'd0 || PixelY !== 4'd0) begin errors++; $display("FAIL mid_rst_xy got %0d,%0d want 0,0", PixelX, PixelY); end
        Reset = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (VideoReady !== 1'b0 || PixelX !== 4'd0) begin errors++; $display("FAIL post_rst_idle got vr=%b x=%0d want 0 0", VideoReady, PixelX); end
        Enable = 1'b1;
        tick();
        checks++;
        if (VideoReady !== 1'b1) begin errors++; $display("FAIL post_rst_vr got %b want 1", VideoReady); end
        video = 24'hABCDEF;
        tick();
        checks++;
        if (FrameStart !== 1'b1 || DataEnable !== 1'b1 || PixelX !== 4'd0 || PixelY !== 4'd0) begin
            errors++; $display("FAIL post_rst_first got fs=%b de=%b xy=%0d,%0d want 1 1 0,0", FrameStart, DataEnable, PixelX, PixelY);
        end
        checks++;
        if ({Red, Green, Blue} !== 24'hABCDEF) begin errors++; $display("FAIL post_rst_rgb got %h want abcdef", {Red, Green, Blue}); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        Enable = 1'b0;
        video  = 24'h0;
        test_reset();
        test_frames();
        test_drain();
        test_toggle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
